bless_nic: RTL

Node-side endpoint for one bufferless (BLESS) router. It owns the far end of the router's local port: it injects core-issued flits into the router's local input and accepts flits the router ejects. It also checks ejected traffic for misrouting and sequence order. One instance sits beside each `brouter` in a mesh, bridging a ready/valid core interface to the router's unbuffered local port.

---
 rtl/bless_nic.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bless_nic.sv
// bless_nic: node-side endpoint for a bufferless router.
// Injects core flits into the router's local input, accepts ejected flits,
// and flags misrouted flits and per-source sequence gaps.
//
// Handshakes: the core injects on inj_valid & inj_ready and pops the ejection
// head on ej_valid & ej_ready. The router consumes the local flit on
// rtr_inj_ok while rtr_ci[valid] is high. Ejected flits cannot be refused.
module bless_nic #(
    parameter int                ADDR_W    = 2,
    parameter logic [ADDR_W-1:0] MY_ADDR   = '0,
    parameter int                SEQ_W     = 3,
    parameter int                AGE_W     = 4,
    parameter int                DATA_W    = 32,
    parameter int                INJ_DEPTH = 4,
    parameter int                EJ_DEPTH  = 4,
    localparam int               CW        = 1 + SEQ_W + 2*ADDR_W + AGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inj_valid,
    input  logic [ADDR_W-1:0] inj_dest,
    input  logic [DATA_W-1:0] inj_data,
    output logic              inj_ready,
    output logic [CW-1:0]     rtr_ci,
    output logic [DATA_W-1:0] rtr_di,
    input  logic              rtr_inj_ok,
    input  logic [CW-1:0]     rtr_co,
    input  logic [DATA_W-1:0] rtr_do,
    output logic              ej_valid,
    output logic [ADDR_W-1:0] ej_src,
    output logic [SEQ_W-1:0]  ej_seq,
    output logic [DATA_W-1:0] ej_data,
    input  logic              ej_ready,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        ooo_cnt,
    output logic              err_misroute
);
    localparam int IPW = $clog2(INJ_DEPTH);
    localparam int EPW = $clog2(EJ_DEPTH);
    localparam int IW  = SEQ_W + ADDR_W + DATA_W;
    localparam int EW  = ADDR_W + SEQ_W + DATA_W;

    // ---------------- injection path ----------------
    logic [IW-1:0]     inj_mem [INJ_DEPTH];
    logic [IPW:0]      inj_wr, inj_rd;
    logic [SEQ_W-1:0]  seq_ctr;
    logic [AGE_W-1:0]  head_age;
    logic              inj_empty, inj_full, inj_push, inj_pop;
    logic [IW-1:0]     inj_head;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign inj_empty = (inj_wr == inj_rd);
    assign inj_full  = (inj_wr[IPW] != inj_rd[IPW]) &&
                       (inj_wr[IPW-1:0] == inj_rd[IPW-1:0]);
    assign inj_push  = inj_valid & ~inj_full;
    assign inj_pop   = rtr_inj_ok & ~inj_empty;
    assign inj_ready = ~inj_full;
    assign inj_head  = inj_mem[inj_rd[IPW-1:0]];

    // Injection pointers, sequence counter and head age.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_wr   <= '0;
            inj_rd   <= '0;
            seq_ctr  <= '0;
            head_age <= '0;
        end else begin
            if (inj_push) begin
                inj_wr  <= inj_wr + 1'b1;
                seq_ctr <= seq_ctr + 1'b1;
            end
            if (inj_pop)
                inj_rd <= inj_rd + 1'b1;
            // A fresh head starts at age 0; a waiting head ages, saturating.
            if (inj_pop || (inj_push && inj_empty))
                head_age <= '0;
            else if (!inj_empty && !rtr_inj_ok && head_age != '1)
                head_age <= head_age + 1'b1;
        end
    end

    // Injection storage; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (inj_push)
            inj_mem[inj_wr[IPW-1:0]] <= {seq_ctr, inj_dest, inj_data};
    end

    // Drive the router's local input from the FIFO head.
    always_comb begin
        rtr_ci = '0;
        rtr_di = '0;
        if (!inj_empty) begin
            rtr_ci = {1'b1, inj_head[IW-1 -: SEQ_W], MY_ADDR,
                      inj_head[DATA_W+ADDR_W-1 -: ADDR_W], head_age};
            rtr_di = inj_head[DATA_W-1:0];
        end
    end

    // ---------------- ejection path ----------------
    logic              co_valid;
    logic [SEQ_W-1:0]  co_seq;
    logic [ADDR_W-1:0] co_src, co_dest;
    logic              unused_age;

    assign co_valid   = rtr_co[CW-1];
    assign co_seq     = rtr_co[CW-2 -: SEQ_W];
    assign co_src     = rtr_co[2*ADDR_W+AGE_W-1 -: ADDR_W];
    assign co_dest    = rtr_co[ADDR_W+AGE_W-1 -: ADDR_W];
    assign unused_age = ^rtr_co[AGE_W-1:0];

    logic [EW-1:0]    ej_mem [EJ_DEPTH];
    logic [EPW:0]     ej_wr, ej_rd;
    logic [SEQ_W-1:0] exp_seq [2**ADDR_W];
    logic             ej_empty, ej_full, ej_pop, ej_mine, ej_write, ej_drop, seq_bad;
    logic [EW-1:0]    ej_head;

    assign ej_empty = (ej_wr == ej_rd);
    assign ej_full  = (ej_wr[EPW] != ej_rd[EPW]) &&
                      (ej_wr[EPW-1:0] == ej_rd[EPW-1:0]);
    assign ej_pop   = ej_ready & ~ej_empty;
    assign ej_mine  = co_valid && (co_dest == MY_ADDR);
    // A full FIFO is also non-empty, so ej_ready guarantees a same-edge pop.
    assign ej_write = ej_mine & (~ej_full | ej_ready);
    assign ej_drop  = ej_mine & ej_full & ~ej_ready;
    assign seq_bad  = (co_seq != exp_seq[co_src]);
    assign ej_head  = ej_mem[ej_rd[EPW-1:0]];

    // Ejection pointers, sequence table and error counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_wr        <= '0;
            ej_rd        <= '0;
            drop_cnt     <= '0;
            ooo_cnt      <= '0;
            err_misroute <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++)
                exp_seq[i] <= '0;
        end else begin
            if (ej_pop)
                ej_rd <= ej_rd + 1'b1;
            if (ej_write) begin
                ej_wr           <= ej_wr + 1'b1;
                exp_seq[co_src] <= co_seq + 1'b1;
                if (seq_bad && ooo_cnt != 8'hFF)
                    ooo_cnt <= ooo_cnt + 1'b1;
            end
            if (ej_drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (co_valid && co_dest != MY_ADDR)
                err_misroute <= 1'b1;
        end
    end

    // Ejection storage; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (ej_write)
            ej_mem[ej_wr[EPW-1:0]] <= {co_src, co_seq, rtr_do};
    end

    // Present the ejection head, zero when empty.
    always_comb begin
        ej_valid = ~ej_empty;
        ej_src   = '0;
        ej_seq   = '0;
        ej_data  = '0;
        if (!ej_empty) begin
            ej_src  = ej_head[EW-1 -: ADDR_W];
            ej_seq  = ej_head[DATA_W+SEQ_W-1 -: SEQ_W];
            ej_data = ej_head[DATA_W-1:0];
        end
    end
endmodule
